// File: rtl/imm_gen_pipe.sv
// Registered, handshaked immediate generator for the decode stage: output register plus one skid entry.
// Optional CSR zimm decode (fmt Z) is enabled by defining IMM_GEN_CSR_ZIMM_EN.
module imm_gen_pipe #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 32,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic             out_unknown,
    output logic [TAG_W-1:0] out_tag,
    output logic [CNT_W-1:0] unk_count
);

    localparam logic [2:0] FMT_NONE = 3'd0;
    localparam logic [2:0] FMT_I    = 3'd1;
    localparam logic [2:0] FMT_S    = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_U    = 3'd4;
    localparam logic [2:0] FMT_J    = 3'd5;
`ifdef IMM_GEN_CSR_ZIMM_EN
    localparam logic [2:0] FMT_Z    = 3'd6;
`endif

    logic [6:0]      opc;
    logic [2:0]      f3;
    logic            b31;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, shamt, shamt_w;
    logic [XLEN-1:0] dec_imm;
    logic [2:0]      dec_fmt;
    logic            dec_unk;
    logic            is_shift;

    assign opc      = in_instr[6:0];
    assign f3       = in_instr[14:12];
    assign b31      = in_instr[31];
    assign is_shift = (f3 == 3'b001) || (f3 == 3'b101);

    assign imm_i = {{(XLEN-12){b31}}, in_instr[31:20]};
    assign imm_s = {{(XLEN-12){b31}}, in_instr[31:25], in_instr[11:7]};
    assign imm_b = {{(XLEN-13){b31}}, b31, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
    assign imm_u = {{(XLEN-31){b31}}, in_instr[30:12], 12'b0};
    assign imm_j = {{(XLEN-21){b31}}, b31, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
    // instr[30] selects SRA vs SRL and never belongs to the shift amount
    assign shamt   = (XLEN == 64) ? XLEN'(in_instr[25:20]) : XLEN'(in_instr[24:20]);
    assign shamt_w = XLEN'(in_instr[24:20]);

    // Immediate decode at input capture
    always_comb begin
        dec_imm = '0;
        dec_fmt = FMT_NONE;
        dec_unk = 1'b0;
        case (opc)
            7'b0000011, 7'b1100111: begin
                dec_fmt = FMT_I;
                dec_imm = imm_i;
            end
            7'b0010011: begin
                dec_fmt = FMT_I;
                dec_imm = is_shift ? shamt : imm_i;
            end
            7'b0011011: begin
                if (XLEN == 64) begin
                    dec_fmt = FMT_I;
                    dec_imm = is_shift ? shamt_w : imm_i;
                end else begin
                    dec_unk = 1'b1;
                end
            end
            7'b0100011: begin
                dec_fmt = FMT_S;
                dec_imm = imm_s;
            end
            7'b1100011: begin
                dec_fmt = FMT_B;
                dec_imm = imm_b;
            end
            7'b0110111, 7'b0010111: begin
                dec_fmt = FMT_U;
                dec_imm = imm_u;
            end
            7'b1101111: begin
                dec_fmt = FMT_J;
                dec_imm = imm_j;
            end
            7'b0110011, 7'b0111011, 7'b0001111: begin
                dec_fmt = FMT_NONE;
            end
            7'b1110011: begin
`ifdef IMM_GEN_CSR_ZIMM_EN
                if (f3[2]) begin
                    dec_fmt = FMT_Z;
                    dec_imm = XLEN'(in_instr[19:15]);
                end
`else
                dec_fmt = FMT_NONE;
`endif
            end
            default: dec_unk = 1'b1;
        endcase
    end

    logic             skid_valid;
    logic [XLEN-1:0]  skid_imm;
    logic [2:0]       skid_fmt;
    logic             skid_unknown;
    logic [TAG_W-1:0] skid_tag;
    logic             in_xfer, out_free;

    assign in_xfer  = in_valid && in_ready;
    assign out_free = !out_valid || out_ready;

    // Output register + skid entry; in_ready mirrors !skid_valid as a flop
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid    <= 1'b0;
            out_imm      <= '0;
            out_fmt      <= FMT_NONE;
            out_unknown  <= 1'b0;
            out_tag      <= '0;
            skid_valid   <= 1'b0;
            skid_imm     <= '0;
            skid_fmt     <= FMT_NONE;
            skid_unknown <= 1'b0;
            skid_tag     <= '0;
            in_ready     <= 1'b1;
            unk_count    <= '0;
        end else if (flush) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
            in_ready   <= 1'b1;
        end else begin
            if (in_xfer && dec_unk && (unk_count != {CNT_W{1'b1}}))
                unk_count <= unk_count + CNT_W'(1);
            if (out_free) begin
                if (skid_valid) begin
                    out_valid   <= 1'b1;
                    out_imm     <= skid_imm;
                    out_fmt     <= skid_fmt;
                    out_unknown <= skid_unknown;
                    out_tag     <= skid_tag;
                    skid_valid  <= 1'b0;
                    in_ready    <= 1'b1;
                end else if (in_xfer) begin
                    out_valid   <= 1'b1;
                    out_imm     <= dec_imm;
                    out_fmt     <= dec_fmt;
                    out_unknown <= dec_unk;
                    out_tag     <= in_tag;
                end else begin
                    out_valid   <= 1'b0;
                end
            end else if (in_xfer) begin
                skid_valid   <= 1'b1;
                skid_imm     <= dec_imm;
                skid_fmt     <= dec_fmt;
                skid_unknown <= dec_unk;
                skid_tag     <= in_tag;
                in_ready     <= 1'b0;
            end
        end
    end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Registered, handshaked immediate generator for the decode stage. It replaces the purely combinational immediate decode.
- Covers all RV32I/RV64I immediate formats (I, S, B, U, J, plus shift-amount handling) and is generalised to XLEN.
- Adds a valid/ready interface with a 2-entry skid buffer, a pipeline flush, a format tag, and a saturating unknown-opcode counter.
- Sits between the IF/ID register and the ID/EX register.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64. Immediates are sign-extended to XLEN.
- TAG_W, 32, width of the sideband tag (PC or other) carried alongside each instruction.
- CNT_W, 8, width of the saturating unknown-opcode counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  discards all buffered entries.
- in_valid  in  1  input instruction valid.
- in_ready  out  1  block can accept an instruction.
- in_instr  in  32  raw instruction word.
- in_tag  in  TAG_W  sideband tag, passed through unchanged.
- out_valid  out  1  output entry valid.
- out_ready  in  1  downstream accepts the output.
- out_imm  out  XLEN  decoded immediate.
- out_fmt  out  3  format: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z (CSR zimm).
- out_unknown  out  1  opcode has no immediate format.
- out_tag  out  TAG_W  tag of the output entry.
- unk_count  out  CNT_W  saturating count of accepted unknown-opcode instructions.

Behaviour:
- Reset (rst=1 at a clock edge):
  - out_valid=0, skid entry invalid, in_ready=1 on the next cycle.
  - out_imm=0, out_fmt=0, out_unknown=0, out_tag=0, unk_count=0.
- Transfers:
  - Input transfer = in_valid & in_ready.
  - Output transfer = out_valid & out_ready.
  - Latency: an accepted instruction appears on out_* the next cycle when the output register is free.
- Storage and ordering:
  - Storage is an output register plus one skid register. FIFO order is preserved.
  - in_ready = !skid_valid. It is a registered signal with no combinational path from out_ready.
  - When the output register holds an entry and out_ready=0, an arriving instruction goes to skid.
  - On the next output transfer, skid moves to the output register.
  - Simultaneous output transfer and input transfer with skid empty: the new entry loads directly into the output register.
- Full condition: both entries valid → in_ready=0. in_valid is ignored and upstream must hold its data.
- Flush:
  - Invalidates both entries on the edge; in_ready=1 the following cycle.
  - Flush wins over a same-cycle input transfer; that instruction is dropped and not counted.
  - unk_count is not cleared by flush.
- Decode is on opcode in_instr[6:0]; all results are sign-extended from instr[31] unless stated:
  - 0000011 LOAD, 1100111 JALR → I: instr[31:20].
  - 0010011 OP-IMM → I, with a shift exception:
    - When funct3 is 001 or 101, imm = shamt, zero-extended.
    - shamt = instr[24:20] for XLEN=32; instr[25:20] for XLEN=64.
    - instr[30] is excluded from the shift amount.
  - 0011011 OP-IMM-32:
    - XLEN=64: I format, with 5-bit shamt for funct3 001/101.
    - XLEN=32: unknown.
  - 0100011 STORE → S: {instr[31:25], instr[11:7]}.
  - 1100011 BRANCH → B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - 0110111 LUI, 0010111 AUIPC → U: {instr[31:12], 12'b0}, sign-extended to XLEN.
  - 1101111 JAL → J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - 0110011, 0111011 (R-type), 0001111 (FENCE), 1110011 (SYSTEM) → fmt NONE, imm 0, out_unknown=0. This is overridden for SYSTEM when the optional feature is enabled.
  - Any other opcode → fmt NONE, imm 0, out_unknown=1.
- Unknown-opcode counter: unk_count increments on every input transfer whose decode flags unknown. It saturates at 2^CNT_W−1 and never wraps.
- Decode happens at input capture; stored entries hold decoded values, not raw instructions.

Optional Feature:
- Macro IMM_GEN_CSR_ZIMM_EN.
- When defined: SYSTEM with funct3[2]=1 (CSRRWI/CSRRSI/CSRRCI) → fmt Z, imm = instr[19:15] zero-extended to XLEN.
- When undefined: all SYSTEM instructions decode as fmt NONE, imm 0, and fmt code 6 is never produced.

Test Plan:
- Reset then single issue, XLEN=32, out_ready=1:
  - 0xFFF00093 → next cycle out_valid=1, out_imm=0xFFFFFFFF, out_fmt=1.
  - 0xFE20AE23 → out_imm=0xFFFFFFFC, fmt=2.
- Back-to-back stream 0xFE000CE3, 0x123452B7, 0x001000EF:
  - Output 0xFFFFFFF8/fmt3, then 0x12345000/fmt4, then 0x00000800/fmt5, on consecutive cycles.
- Shifts: 0x00309093 → imm 3; 0x4030D093 → imm 3 (not 0x403); both fmt 1.
- Backpressure:
  - out_ready=0 while 3 instructions are offered → two accepted, in_ready=0 from the cycle after the second.
  - Release out_ready → both emitted in order; in_ready returns to 1.
- Flush with both entries full and in_valid=1 on the same cycle → out_valid=0 next cycle, offered instruction dropped, unk_count unchanged.
- Unknown opcode and CSR immediate:
  - 300 instructions with opcode 0x7F, CNT_W=8 → unk_count=255 (saturated), out_unknown=1 each.
  - With IMM_GEN_CSR_ZIMM_EN: 0x3401D073 → fmt 6, imm 3.
